// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_if
//  Purpose  : Run-control / hazard bundle between the pipeline and pipe_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             step;
    logic             stop;
    logic [15:0]      id_ir;
    logic [15:0]      ex_ir;
    logic             zf;
    logic             nf;
    logic             cf;
    logic             state;
    logic             stall;
    logic             flush;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output start, step, stop, id_ir, ex_ir, zf, nf, cf,
        input  state, stall, flush, halted, cycle_cnt
    );

    modport slave (
        input  start, step, stop, id_ir, ex_ir, zf, nf, cf,
        output state, stall, flush, halted, cycle_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Start/step/stop/halt FSM, load-use stall and branch flush for
//             the 16-bit five-stage pipeline, plus an exec-cycle counter.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  wire logic   clock,
    input  wire logic   reset,
    pipe_ctrl_if.slave  bus
);
    localparam logic [4:0] c_OP_NOP  = 5'b00000;
    localparam logic [4:0] c_OP_HALT = 5'b00001;
    localparam logic [4:0] c_OP_LOAD = 5'b00010;
    localparam logic [4:0] c_OP_JUMP = 5'b11000;
    localparam logic [4:0] c_OP_JMPR = 5'b11001;
    localparam logic [4:0] c_OP_BZ   = 5'b11010;
    localparam logic [4:0] c_OP_BNZ  = 5'b11011;
    localparam logic [4:0] c_OP_BN   = 5'b11100;
    localparam logic [4:0] c_OP_BNN  = 5'b11101;
    localparam logic [4:0] c_OP_BC   = 5'b11110;
    localparam logic [4:0] c_OP_BNC  = 5'b11111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t           r_fsm;
    state_t           w_fsm_nxt;
    logic [CNT_W-1:0] r_cycle_cnt;

    logic [4:0] w_ex_op;
    logic [4:0] w_id_op;
    logic [2:0] w_ex_r1;
    logic       w_exec;
    logic       w_taken;
    logic       w_hazard;
    logic       w_unused;

    assign w_ex_op  = bus.ex_ir[15:11];
    assign w_id_op  = bus.id_ir[15:11];
    assign w_ex_r1  = bus.ex_ir[10:8];
    assign w_unused = ^{bus.ex_ir[7:0], bus.id_ir[7], bus.id_ir[3]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE: begin
                if (bus.start) begin
                    w_fsm_nxt = S_RUN;
                end else if (bus.step) begin
                    w_fsm_nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (w_ex_op == c_OP_HALT) begin
                    w_fsm_nxt = S_HALT;
                end else if (bus.stop) begin
                    w_fsm_nxt = S_IDLE;
                end
            end
            S_STEP: begin
                w_fsm_nxt = (w_ex_op == c_OP_HALT) ? S_HALT : S_IDLE;
            end
            S_HALT: begin
                w_fsm_nxt = S_HALT;
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    assign w_exec = (r_fsm == S_RUN) || (r_fsm == S_STEP);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt <= '0;
        end else if (w_exec) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_ex_op)
            c_OP_JUMP, c_OP_JMPR: w_taken = 1'b1;
            c_OP_BZ:              w_taken = bus.zf;
            c_OP_BNZ:             w_taken = ~bus.zf;
            c_OP_BN:              w_taken = bus.nf;
            c_OP_BNN:             w_taken = ~bus.nf;
            c_OP_BC:              w_taken = bus.cf;
            c_OP_BNC:             w_taken = ~bus.cf;
            default:              w_taken = 1'b0;
        endcase
    end

    // Compare against all three ID fields regardless of which ones the opcode reads.
    always_comb begin
        w_hazard = 1'b0;
        if ((w_ex_op == c_OP_LOAD) &&
            (w_id_op != c_OP_NOP) && (w_id_op != c_OP_HALT) && (w_id_op != c_OP_JUMP)) begin
            w_hazard = (w_ex_r1 == bus.id_ir[10:8]) ||
                       (w_ex_r1 == bus.id_ir[6:4])  ||
                       (w_ex_r1 == bus.id_ir[2:0]);
        end
    end

    assign bus.state     = w_exec;
    assign bus.halted    = (r_fsm == S_HALT);
    assign bus.flush     = w_exec & w_taken;
    assign bus.stall     = w_exec & w_hazard & ~w_taken;
    assign bus.cycle_cnt = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Scoreboard bench for pipe_ctrl: directed scenarios plus random
//             stimulus checked against a behavioural run-control model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;
    localparam logic [4:0] NOP  = 5'b00000, HALT = 5'b00001, LOAD = 5'b00010,
                           STORE = 5'b00011, ADD = 5'b01000, SUB = 5'b01010,
                           CMP  = 5'b01100, JUMP = 5'b11000, JMPR = 5'b11001,
                           BZ   = 5'b11010, BNZ  = 5'b11011, BN   = 5'b11100,
                           BNN  = 5'b11101, BC   = 5'b11110, BNC  = 5'b11111;

    typedef struct packed {
        logic        state;
        logic        stall;
        logic        flush;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pipe_ctrl_if #(.CNT_W(16)) bus ();
    pipe_ctrl #(.CNT_W(16)) dut (.clock(clock), .reset(reset), .bus(bus));

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Behavioural model of the run controller
    bit m_run, m_step, m_halt;
    int m_cnt;

    // Stimulus for the next tick
    logic        s_rst, s_start, s_step, s_stop, s_zf, s_nf, s_cf;
    logic [15:0] s_id, s_ex;

    logic [4:0] ops [14] = '{NOP, LOAD, STORE, ADD, SUB, CMP, JUMP, JMPR,
                             BZ, BNZ, BN, BNN, BC, BNC};

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] ins(input logic [4:0] op, input int a, input int b, input int c);
        return {op, a[2:0], 1'b0, b[2:0], 1'b0, c[2:0]};
    endfunction

    function automatic bit is_taken(input logic [15:0] ir, input bit z, input bit n, input bit c);
        case (ir[15:11])
            JUMP, JMPR: return 1'b1;
            BZ:  return z;
            BNZ: return !z;
            BN:  return n;
            BNN: return !n;
            BC:  return c;
            BNC: return !c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_hazard(input logic [15:0] id, input logic [15:0] ex);
        int dst;
        dst = int'(ex[10:8]);
        if (ex[15:11] != LOAD) return 1'b0;
        if (id[15:11] == NOP || id[15:11] == HALT || id[15:11] == JUMP) return 1'b0;
        return (dst == int'(id[10:8])) || (dst == int'(id[6:4])) || (dst == int'(id[2:0]));
    endfunction

    function automatic logic [15:0] rand_ir();
        logic [4:0] op;
        if ($urandom_range(0, 39) == 0) op = HALT;
        else op = ops[$urandom_range(0, 13)];
        return ins(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    endfunction

    task automatic model_clear();
        m_run = 0; m_step = 0; m_halt = 0; m_cnt = 0;
    endtask

    task automatic set_idle_inputs();
        s_rst = 1; s_start = 0; s_step = 0; s_stop = 0;
        s_zf = 0; s_nf = 0; s_cf = 0;
        s_id = ins(NOP, 0, 0, 0); s_ex = ins(NOP, 0, 0, 0);
    endtask

    // Apply one clock of stimulus, queue the expected response, advance the model.
    task automatic tick();
        exp_t e;
        bit   ex_on;
        @(posedge clock);
        #1;
        reset = s_rst; bus.start = s_start; bus.step = s_step; bus.stop = s_stop;
        bus.id_ir = s_id; bus.ex_ir = s_ex; bus.zf = s_zf; bus.nf = s_nf; bus.cf = s_cf;
        ex_on    = s_rst && (m_run || m_step);
        e.state  = ex_on;
        e.flush  = ex_on && is_taken(s_ex, s_zf, s_nf, s_cf);
        e.stall  = ex_on && is_hazard(s_id, s_ex) && !e.flush;
        e.halted = s_rst && m_halt;
        e.cnt    = s_rst ? 16'(m_cnt) : 16'd0;
        exp_q.push_back(e);
        if (!s_rst) begin
            model_clear();
        end else begin
            if (ex_on) m_cnt = (m_cnt + 1) % 65536;
            if (m_halt) begin
                m_halt = 1;
            end else if (m_run) begin
                if (s_ex[15:11] == HALT) begin m_run = 0; m_halt = 1; end
                else if (s_stop) m_run = 0;
            end else if (m_step) begin
                m_step = 0;
                m_halt = (s_ex[15:11] == HALT);
            end else if (s_start) begin
                m_run = 1;
            end else if (s_step) begin
                m_step = 1;
            end
        end
    endtask

    task automatic do_reset();
        s_rst = 0; tick(); tick();
        s_rst = 1;
    endtask

    // Scoreboard monitor: compare every queued expectation away from the clock edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb.state",  int'(bus.state),     int'(e.state));
                chk("sb.stall",  int'(bus.stall),     int'(e.stall));
                chk("sb.flush",  int'(bus.flush),     int'(e.flush));
                chk("sb.halted", int'(bus.halted),    int'(e.halted));
                chk("sb.cnt",    int'(bus.cycle_cnt), int'(e.cnt));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        set_idle_inputs();
        bus.start = 0; bus.step = 0; bus.stop = 0; bus.zf = 0; bus.nf = 0; bus.cf = 0;
        bus.id_ir = '0; bus.ex_ir = '0;

        // Reset state
        do_reset();
        #1;
        chk("rst.state", int'(bus.state), 0);
        chk("rst.halted", int'(bus.halted), 0);
        chk("rst.cnt", int'(bus.cycle_cnt), 0);

        // start pulse then NOPs
        s_start = 1; tick(); s_start = 0;
        for (int i = 1; i <= 6; i++) begin
            tick(); #1;
            if (i == 1) chk("start.exec_next_edge", int'(bus.state), 1);
        end
        chk("start.cnt5", int'(bus.cycle_cnt), 5);
        chk("start.stall", int'(bus.stall), 0);
        chk("start.flush", int'(bus.flush), 0);

        // Load-use hazard
        s_ex = ins(LOAD, 3, 0, 0); s_id = ins(ADD, 1, 3, 2); tick(); #1;
        chk("lu.stall", int'(bus.stall), 1);
        s_ex = ins(NOP, 0, 0, 0); tick(); #1;
        chk("lu.bubble_clears", int'(bus.stall), 0);
        s_ex = ins(LOAD, 3, 0, 0); s_id = ins(ADD, 1, 2, 4); tick(); #1;
        chk("lu.no_match", int'(bus.stall), 0);

        // Branch decode
        s_id = ins(NOP, 0, 0, 0);
        s_ex = ins(BZ, 0, 0, 0); s_zf = 1; tick(); #1;
        chk("br.bz_taken", int'(bus.flush), 1);
        s_zf = 0; tick(); #1;
        chk("br.bz_not", int'(bus.flush), 0);
        s_ex = ins(BNC, 0, 0, 0); s_cf = 0; tick(); #1;
        chk("br.bnc_taken", int'(bus.flush), 1);
        s_ex = ins(BZ, 3, 0, 0); s_zf = 1; s_id = ins(ADD, 1, 3, 2); tick(); #1;
        chk("br.bz_hz_flush", int'(bus.flush), 1);
        chk("br.bz_hz_stall", int'(bus.stall), 0);

        // stop returns to idle, outputs gated off
        set_idle_inputs(); s_stop = 1; tick(); s_stop = 0;
        s_ex = ins(LOAD, 3, 0, 0); s_id = ins(ADD, 3, 3, 3); tick(); #1;
        chk("idle.state", int'(bus.state), 0);
        chk("idle.stall", int'(bus.stall), 0);

        // Single-step held for several cycles
        set_idle_inputs(); do_reset();
        s_step = 1; tick();
        for (int i = 1; i <= 6; i++) begin
            tick(); #1;
            chk("step.state", int'(bus.state), i % 2);
        end
        chk("step.cnt3", int'(bus.cycle_cnt), 3);
        s_step = 0;

        // HALT beats stop; HALT is sticky until reset
        set_idle_inputs(); do_reset();
        s_start = 1; tick(); s_start = 0; tick(); tick();
        s_ex = ins(HALT, 0, 0, 0); s_stop = 1; tick();
        set_idle_inputs(); tick(); #1;
        chk("halt.halted", int'(bus.halted), 1);
        chk("halt.state", int'(bus.state), 0);
        s_start = 1; tick(); s_start = 0; tick(); #1;
        chk("halt.sticky", int'(bus.halted), 1);
        chk("halt.sticky_state", int'(bus.state), 0);
        s_rst = 0; tick(); #1;
        chk("halt.rst_halted", int'(bus.halted), 0);
        chk("halt.rst_cnt", int'(bus.cycle_cnt), 0);
        s_rst = 1;

        // Counter wrap
        set_idle_inputs(); do_reset();
        s_start = 1; tick(); s_start = 0;
        for (int i = 1; i <= 65536; i++) tick();
        #1;
        chk("wrap.ffff", int'(bus.cycle_cnt), 65535);
        tick(); #1;
        chk("wrap.zero", int'(bus.cycle_cnt), 0);

        // Asynchronous reset mid-cycle
        s_ex = ins(BZ, 0, 0, 0); s_zf = 1; tick();
        @(posedge clock); #1;
        chk("async.pre_state", int'(bus.state), 1);
        chk("async.pre_flush", int'(bus.flush), 1);
        #2; reset = 0; #1;
        chk("async.state", int'(bus.state), 0);
        chk("async.flush", int'(bus.flush), 0);
        chk("async.stall", int'(bus.stall), 0);
        chk("async.halted", int'(bus.halted), 0);
        chk("async.cnt", int'(bus.cycle_cnt), 0);
        model_clear();
        set_idle_inputs(); s_rst = 0; tick(); s_rst = 1;

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            s_rst   = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            s_start = ($urandom_range(0, 9) == 0);
            s_step  = ($urandom_range(0, 9) == 0);
            s_stop  = ($urandom_range(0, 19) == 0);
            s_ex    = rand_ir();
            s_id    = rand_ir();
            s_zf    = 1'($urandom_range(0, 1));
            s_nf    = 1'($urandom_range(0, 1));
            s_cf    = 1'($urandom_range(0, 1));
            tick();
        end
        set_idle_inputs(); tick();
        @(posedge clock); @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
